// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iir_pkg
// Brief    : Shared constants, FSM encoding and arithmetic helpers for the
//            time-multiplexed biquad cascade.
// Revision : 1.0 - initial release
// ============================================================================
package iir_pkg;

    localparam int COEF_PER_SEC = 5;
    localparam int IDX_A1       = 0;
    localparam int IDX_A2       = 1;
    localparam int IDX_B0       = 2;
    localparam int IDX_B1       = 3;
    localparam int IDX_B2       = 4;

    // Accumulator base selection for the MAC unit
    localparam logic [1:0] BASE_ZERO = 2'd0;
    localparam logic [1:0] BASE_X    = 2'd1;
    localparam logic [1:0] BASE_ACC  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int coef_aw(input int nsec);
        return $clog2(COEF_PER_SEC * nsec);
    endfunction

    // Clamp a sign-extended accumulator value to a w-bit signed range
    function automatic logic signed [63:0] sat(input logic signed [63:0] acc, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (acc > hi) begin
            return hi;
        end else if (acc < lo) begin
            return lo;
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iir_mac_unit.sv
`default_nettype none
// ============================================================================
// Module   : iir_mac_unit
// Brief    : Single multiplier with FRAC shift, guarded accumulator and
//            saturating view of the running sum.
// Revision : 1.0 - initial release
// ============================================================================
module iir_mac_unit
    import iir_pkg::*;
#(
    parameter int W     = 25,
    parameter int FRAC  = 16,
    parameter int GUARD = 4
) (
    input  logic                clk,
    input  logic                i_en,
    input  logic [1:0]          i_base_sel,
    input  logic signed [W-1:0] i_x,
    input  logic signed [W-1:0] i_coef,
    input  logic signed [W-1:0] i_opnd,
    output logic signed [W-1:0] o_sat
);

    localparam int ACC_W = W + GUARD;

    logic signed [2*W-1:0]   w_prod;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] r_acc;

    // Arithmetic shift floors toward -inf before narrowing into the accumulator
    assign w_prod = (2*W)'(i_coef) * (2*W)'(i_opnd);
    assign w_term = ACC_W'(w_prod >>> FRAC);

    always_comb begin
        w_base = '0;
        case (i_base_sel)
            BASE_X:   w_base = ACC_W'(i_x);
            BASE_ACC: w_base = r_acc;
            default:  w_base = '0;
        endcase
    end

    assign w_sum = w_base + w_term;
    assign o_sat = W'(sat(64'(w_sum), W));

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_acc <= w_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/iir_biquad_cascade.sv
`default_nettype none
// ============================================================================
// Module   : iir_biquad_cascade
// Brief    : NSEC cascaded DF-II biquads sharing one MAC, five products per
//            section, with runtime-writable coefficients.
// Revision : 1.0 - initial release
// ============================================================================
module iir_biquad_cascade
    import iir_pkg::*;
#(
    parameter int W     = 25,
    parameter int FRAC  = 16,
    parameter int NSEC  = 2,
    parameter int GUARD = 4
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [W-1:0]        u,
    output logic signed [W-1:0]        y,
    output logic                       out_valid,
    input  logic                       coef_we,
    input  logic [coef_aw(NSEC)-1:0]   coef_addr,
    input  logic signed [W-1:0]        coef_data,
    input  logic                       clear_state
);

    localparam int NCOEF = COEF_PER_SEC * NSEC;
    localparam int AW    = coef_aw(NSEC);
    localparam int SW    = (NSEC > 1) ? $clog2(NSEC) : 1;

    state_t              r_state;
    state_t              w_next;
    logic signed [W-1:0] r_coef [NCOEF];
    logic signed [W-1:0] r_w1   [NSEC];
    logic signed [W-1:0] r_w2   [NSEC];
    logic signed [W-1:0] r_w;
    logic signed [W-1:0] r_x;
    logic [SW-1:0]       r_sec;
    logic [2:0]          r_k;
    logic [AW-1:0]       r_base;
    logic [AW-1:0]       w_cidx;
    logic                w_last;
    logic [1:0]          w_base_sel;
    logic signed [W-1:0] w_opnd;
    logic signed [W-1:0] w_coef;
    logic signed [W-1:0] w_sat;

    assign in_ready = Reset && (r_state != RUN);
    assign w_last   = (r_sec == SW'(NSEC - 1));

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = RUN;
            RUN:     if (r_k == 3'd4 && w_last) w_next = DONE;
            DONE:    w_next = in_valid ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Step k selects coefficient index k directly: a1, a2, b0, b1, b2
    always_comb begin
        w_cidx     = r_base + AW'(r_k);
        w_opnd     = r_w2[r_sec];
        w_base_sel = BASE_ACC;
        case (r_k)
            3'd0: begin w_opnd = r_w1[r_sec]; w_base_sel = BASE_X;    end
            3'd1: begin w_opnd = r_w2[r_sec]; w_base_sel = BASE_ACC;  end
            3'd2: begin w_opnd = r_w;         w_base_sel = BASE_ZERO; end
            3'd3: begin w_opnd = r_w1[r_sec]; w_base_sel = BASE_ACC;  end
            default: begin w_opnd = r_w2[r_sec]; w_base_sel = BASE_ACC; end
        endcase
    end

    assign w_coef = r_coef[w_cidx];

    iir_mac_unit #(
        .W     (W),
        .FRAC  (FRAC),
        .GUARD (GUARD)
    ) u_mac (
        .clk        (CLK),
        .i_en       (r_state == RUN),
        .i_base_sel (w_base_sel),
        .i_x        (r_x),
        .i_coef     (w_coef),
        .i_opnd     (w_opnd),
        .o_sat      (w_sat)
    );

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            y         <= '0;
            out_valid <= 1'b0;
            r_w       <= '0;
            r_x       <= '0;
            r_sec     <= '0;
            r_k       <= '0;
            r_base    <= '0;
            for (int i = 0; i < NSEC; i++) begin
                r_w1[i] <= '0;
                r_w2[i] <= '0;
            end
            for (int i = 0; i < NCOEF; i++) begin
                r_coef[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (r_state != RUN) begin
                if (r_state == IDLE && coef_we && int'(coef_addr) < NCOEF) begin
                    r_coef[coef_addr] <= coef_data;
                end
                if (r_state == IDLE && clear_state) begin
                    for (int i = 0; i < NSEC; i++) begin
                        r_w1[i] <= '0;
                        r_w2[i] <= '0;
                    end
                end
                if (r_state == DONE) begin
                    y         <= r_x;
                    out_valid <= 1'b1;
                end
                if (in_valid) begin
                    r_x    <= u;
                    r_sec  <= '0;
                    r_k    <= '0;
                    r_base <= '0;
                end
            end else begin
                if (r_k == 3'd1) begin
                    r_w <= w_sat;
                end
                // Section output becomes the next section's input
                if (r_k == 3'd4) begin
                    r_x         <= w_sat;
                    r_w2[r_sec] <= r_w1[r_sec];
                    r_w1[r_sec] <= r_w;
                    r_k         <= '0;
                    r_sec       <= r_sec + 1'b1;
                    r_base      <= r_base + AW'(COEF_PER_SEC);
                end else begin
                    r_k <= r_k + 3'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iir_biquad_cascade.sv
`default_nettype none
// ============================================================================
// Module   : tb_iir_biquad_cascade
// Brief    : Directed checks of the two-section biquad cascade (W=25, FRAC=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_iir_biquad_cascade;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] u = '0;
    logic [24:0] y;
    logic        out_valid;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [24:0] coef_data = '0;
    logic        clear_state = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    iir_biquad_cascade #(.W(25), .FRAC(16), .NSEC(2), .GUARD(4)) dut (
        .CLK         (clk),
        .Reset       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .u           (u),
        .y           (y),
        .out_valid   (out_valid),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .clear_state (clear_state)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [3:0] a, input logic [24:0] d);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    // wmode: 0 none, 1 write with the accepting edge, 2 write during RUN, 3 write during DONE
    task automatic run_sample(input logic [24:0] x, input logic clr, input int wmode,
                              input logic [3:0] wa, input logic [24:0] wd,
                              output logic [24:0] yo, output int lat);
        u = x; in_valid = 1'b1; clear_state = clr;
        if (wmode == 1) begin coef_we = 1'b1; coef_addr = wa; coef_data = wd; end
        @(posedge clk); #1;
        in_valid = 1'b0; clear_state = 1'b0; coef_we = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if ((wmode == 2 && i == 4) || (wmode == 3 && i == 11)) begin
                coef_we = 1'b1; coef_addr = wa; coef_data = wd;
            end
            @(posedge clk); #1;
            coef_we = 1'b0;
            if (out_valid) begin lat = i; break; end
        end
        yo = y;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (y !== 25'h0) $display("FAIL reset_y: got %h expected 0", y); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_low: got %b expected 0", in_ready); else n_pass++;
        rst_n = 1'b1; #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready_release: got %b expected 1", in_ready); else n_pass++;
    endtask

    task automatic test_zero_coefs;
        logic [24:0] yo; int lat;
        run_sample(25'h10000, 1'b0, 0, 4'd0, 25'h0, yo, lat);
        n_total++; if (yo !== 25'h0) $display("FAIL zero_coefs: got %h expected 0", yo); else n_pass++;
    endtask

    task automatic test_passthrough;
        logic [24:0] yo; int lat;
        wr(4'd2, 25'h10000); wr(4'd7, 25'h10000);
        run_sample(25'h08000, 1'b0, 0, 4'd0, 25'h0, yo, lat);
        n_total++; if (lat !== 11) $display("FAIL pass_latency: got %0d expected 11", lat); else n_pass++;
        n_total++; if (yo !== 25'h08000) $display("FAIL pass_value: got %h expected 08000", yo); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL pass_pulse_width: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (y !== 25'h08000) $display("FAIL pass_hold: got %h expected 08000", y); else n_pass++;
        run_sample(25'h1FF8000, 1'b0, 0, 4'd0, 25'h0, yo, lat);
        n_total++; if (yo !== 25'h1FF8000) $display("FAIL pass_negative: got %h expected 1ff8000", yo); else n_pass++;
    endtask

    task automatic test_rounding;
        logic [24:0] yo; int lat;
        wr(4'd2, 25'h08000);
        run_sample(25'h1FFFFFF, 1'b0, 0, 4'd0, 25'h0, yo, lat);
        n_total++; if (yo !== 25'h1FFFFFF) $display("FAIL floor_negative: got %h expected 1ffffff", yo); else n_pass++;
        run_sample(25'h0000003, 1'b0, 0, 4'd0, 25'h0, yo, lat);
        n_total++; if (yo !== 25'h0000001) $display("FAIL floor_positive: got %h expected 0000001", yo); else n_pass++;
    endtask

    task automatic test_decay;
        logic [24:0] yo; int lat;
        logic [24:0] exp_seq [4];
        exp_seq[0] = 25'h10000; exp_seq[1] = 25'h08000; exp_seq[2] = 25'h04000; exp_seq[3] = 25'h02000;
        wr(4'd2, 25'h10000); wr(4'd0, 25'h08000);
        for (int i = 0; i < 4; i++) begin
            run_sample((i == 0) ? 25'h10000 : 25'h0, (i == 0), 0, 4'd0, 25'h0, yo, lat);
            n_total++; if (yo !== exp_seq[i]) $display("FAIL decay_%0d: got %h expected %h", i, yo, exp_seq[i]); else n_pass++;
        end
        run_sample(25'h10000, 1'b1, 0, 4'd0, 25'h0, yo, lat);
        n_total++; if (yo !== 25'h10000) $display("FAIL clear_with_sample: got %h expected 10000", yo); else n_pass++;
    endtask

    task automatic test_saturation;
        logic [24:0] yo; int lat;
        wr(4'd0, 25'h0); wr(4'd2, 25'h20000); wr(4'd7, 25'h20000);
        run_sample(25'h0640000, 1'b0, 0, 4'd0, 25'h0, yo, lat);
        n_total++; if (yo !== 25'h0FFFFFF) $display("FAIL sat_pos: got %h expected 0ffffff", yo); else n_pass++;
        run_sample(25'h19C0000, 1'b0, 0, 4'd0, 25'h0, yo, lat);
        n_total++; if (yo !== 25'h1000000) $display("FAIL sat_neg: got %h expected 1000000", yo); else n_pass++;
    endtask

    task automatic test_busy_write;
        logic [24:0] yo; int lat;
        wr(4'd2, 25'h10000); wr(4'd7, 25'h10000);
        run_sample(25'h08000, 1'b0, 2, 4'd2, 25'h0, yo, lat);
        n_total++; if (yo !== 25'h08000) $display("FAIL busy_run_write: got %h expected 08000", yo); else n_pass++;
        run_sample(25'h04000, 1'b0, 3, 4'd2, 25'h0, yo, lat);
        n_total++; if (yo !== 25'h04000) $display("FAIL busy_next_sample: got %h expected 04000", yo); else n_pass++;
        run_sample(25'h04000, 1'b0, 0, 4'd0, 25'h0, yo, lat);
        n_total++; if (yo !== 25'h04000) $display("FAIL busy_done_write: got %h expected 04000", yo); else n_pass++;
        wr(4'd2, 25'h0);
        run_sample(25'h04000, 1'b0, 0, 4'd0, 25'h0, yo, lat);
        n_total++; if (yo !== 25'h0) $display("FAIL idle_write: got %h expected 0", yo); else n_pass++;
        run_sample(25'h01000, 1'b0, 1, 4'd2, 25'h20000, yo, lat);
        n_total++; if (yo !== 25'h02000) $display("FAIL write_with_sample: got %h expected 02000", yo); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int          t [3];
        logic [24:0] v [3];
        int          np = 0;
        wr(4'd2, 25'h10000); wr(4'd0, 25'h08000);
        clear_state = 1'b1; @(posedge clk); #1; clear_state = 1'b0;
        u = 25'h10000; in_valid = 1'b1;
        for (int i = 1; i <= 60 && np < 3; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin t[np] = i; v[np] = y; np++; end
        end
        in_valid = 1'b0;
        n_total++; if (np !== 3) $display("FAIL b2b_count: got %0d expected 3", np); else n_pass++;
        n_total++; if (t[1] - t[0] !== 11) $display("FAIL b2b_period1: got %0d expected 11", t[1] - t[0]); else n_pass++;
        n_total++; if (t[2] - t[1] !== 11) $display("FAIL b2b_period2: got %0d expected 11", t[2] - t[1]); else n_pass++;
        n_total++; if (v[0] !== 25'h10000) $display("FAIL b2b_y0: got %h expected 10000", v[0]); else n_pass++;
        n_total++; if (v[1] !== 25'h18000) $display("FAIL b2b_y1: got %h expected 18000", v[1]); else n_pass++;
        n_total++; if (v[2] !== 25'h1C000) $display("FAIL b2b_y2: got %h expected 1c000", v[2]); else n_pass++;
        repeat (15) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run;
        logic [24:0] yo; int lat;
        int pulses = 0;
        u = 25'h10000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL midrst_ready_low: got %b expected 0", in_ready); else n_pass++;
        rst_n = 1'b1; #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL midrst_ready_high: got %b expected 1", in_ready); else n_pass++;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        n_total++; if (pulses !== 0) $display("FAIL midrst_no_valid: got %0d pulses expected 0", pulses); else n_pass++;
        n_total++; if (y !== 25'h0) $display("FAIL midrst_y: got %h expected 0", y); else n_pass++;
        wr(4'd2, 25'h10000); wr(4'd7, 25'h10000); wr(4'd0, 25'h08000);
        run_sample(25'h10000, 1'b0, 0, 4'd0, 25'h0, yo, lat);
        n_total++; if (yo !== 25'h10000) $display("FAIL midrst_impulse: got %h expected 10000", yo); else n_pass++;
        run_sample(25'h0, 1'b0, 0, 4'd0, 25'h0, yo, lat);
        n_total++; if (yo !== 25'h08000) $display("FAIL midrst_decay: got %h expected 08000", yo); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero_coefs();
        test_passthrough();
        test_rounding();
        test_decay();
        test_saturation();
        test_busy_write();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iir_biquad_cascade.md
Name: iir_biquad_cascade

Overview:
Parametrised successor to the team's single fixed-width biquad filter. Implements NSEC cascaded direct-form-II biquad sections in signed fixed point, using one time-multiplexed multiply-accumulate datapath. Coefficients are runtime-writable. Samples move through a valid/ready handshake, replacing the old free-running clock-divider enable. Sits between the ADC sample stage and the output/DAC stage of the signal path.

Parameters:
W, 25, sample/coefficient/state width (signed two's complement).
FRAC, 16, fractional bits; format is Q(W-FRAC-1).FRAC, so 1.0 = 2^FRAC.
NSEC, 2, number of cascaded biquad sections (1..8).
GUARD, 4, extra accumulator headroom bits; accumulator width is W+GUARD.

Ports:
CLK  in  1  system clock; all logic on rising edge.
Reset  in  1  synchronous, active-low reset.
in_valid  in  1  input sample u is valid.
in_ready  out  1  block can accept a sample this cycle.
u  in  W  input sample.
y  out  W  filtered output; holds its value between updates.
out_valid  out  1  one-cycle pulse; y is new this cycle.
coef_we  in  1  coefficient write strobe.
coef_addr  in  clog2(5*NSEC)  address = 5*section + idx; idx 0..4 = a1, a2, b0, b1, b2.
coef_data  in  W  coefficient value.
clear_state  in  1  zero all section state (w1, w2) when idle.

Behaviour:
- Reset (Reset=0 on an edge):
  - y=0, out_valid=0, FSM to IDLE.
  - All w1/w2 state = 0. All coefficients = 0.
  - in_ready=0 while Reset is low; in_ready=1 in the first cycle after release.
- FSM IDLE:
  - in_ready=1.
  - in_valid=1 captures u, sets section s=0, step k=0, goes to RUN.
- FSM RUN:
  - in_ready=0.
  - One product per cycle, 5 cycles per section. x = u for s=0, otherwise y of section s-1.
  - k0: acc = x + a1*w1.
  - k1: w = sat(acc + a2*w2).
  - k2: acc = b0*w.
  - k3: acc += b1*w1.
  - k4: y_s = sat(acc + b2*w2); then w2<=w1 and w1<=w.
  - After k4 of the last section, go to DONE.
- FSM DONE (one cycle):
  - y <= y of last section; out_valid=1; in_ready=1.
  - A sample offered with in_valid in this cycle is accepted (back-to-back operation).
  - Otherwise go to IDLE.
- Latency and throughput:
  - out_valid asserts exactly 5*NSEC+1 cycles after the accepting edge (11 cycles for NSEC=2).
  - Maximum throughput is one sample per 5*NSEC+1 cycles.
- Sign convention: feedback coefficients are stored pre-negated; w = x + a1*w1 + a2*w2.
- Arithmetic:
  - Product is 2W bits, arithmetically shifted right by FRAC (truncation toward -inf), then sign-extended into a W+GUARD accumulator.
  - The input x is sign-extended into the accumulator without shifting.
  - sat() clamps to [-2^(W-1), 2^(W-1)-1].
  - Saturation is applied only at k1 and k4. The accumulator never wraps within GUARD headroom.
- Coefficient writes:
  - Accepted only in IDLE. Ignored in RUN and DONE, with no side effect.
  - Addresses at or above 5*NSEC are ignored.
  - A write and an in_valid in the same IDLE cycle: the write lands first, and the new sample uses the new coefficient.
- clear_state:
  - Honoured only in IDLE; zeroes all w1/w2 and leaves y unchanged.
  - If clear_state and in_valid arrive together, state is cleared and the sample is processed with zero state.
- Reset mid-operation (Reset=0 during RUN):
  - Aborts the computation; no out_valid is produced.
  - All state is zeroed as in a full reset.
- out_valid is never asserted except in DONE. There is no output backpressure; the consumer must take y on the pulse.

Decomposition:
- Package iir_pkg holds:
  - Constants COEF_PER_SEC=5 and IDX_A1..IDX_B2 = 0..4.
  - FSM state enum {IDLE, RUN, DONE}.
  - Saturate function sat(acc) parametrised on W/GUARD.
  - Helper for the coef_addr width.
- Sub-module iir_mac_unit: one multiplier, FRAC shift, accumulator (load/accumulate select), and saturating output. Purely datapath; the FSM and the coefficient/state register files stay in the top level.

Test Plan:
All cases use W=25, FRAC=16, NSEC=2.
- Passthrough: b0=0x10000 in both sections, all other coefficients 0; u=0x08000 -> out_valid exactly 11 cycles after acceptance, y=0x08000.
- Recursive decay: section0 a1=0x08000, b0=0x10000; section1 passthrough; impulse u=0x10000, then u=0 three times -> y = 0x10000, 0x08000, 0x04000, 0x02000.
- Saturation: b0=0x20000 (2.0) in both sections; u=0x640000 (100.0) -> y=0x0FFFFFF. u=-100.0 -> y=0x1000000 (-256.0).
- Busy write ignored: coef_we with b0=0 during RUN -> that sample and the next still use the old b0. The same write in IDLE takes effect on the next sample.
- Reset mid-run: Reset=0 at cycle 5 of RUN for one cycle -> no out_valid, y=0, in_ready=1 next cycle. A following impulse behaves as from zero state.
- Back-to-back and clear: in_valid held high -> a sample is accepted on every DONE cycle (period 11 cycles). clear_state asserted during the recursive-decay test -> the next output equals b0*u only.
